shift_engine: RTL and testbench

//  Parametrised successor to the single-bit serial shift register in the top-level project.

---
 rtl/shift_engine_pkg.sv | 22 ++
 rtl/shift_engine_shift_step.sv | 24 ++
 rtl/shift_engine.sv | 90 +++++++++
 tb/tb_shift_engine.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_engine_pkg.sv
// Shared types for the shift engine: mode codes, FSM state encoding and a mode helper.
package shift_engine_pkg;

   typedef enum logic [1:0] {
      MODE_SHL = 2'd0,
      MODE_SHR = 2'd1,
      MODE_ROL = 2'd2,
      MODE_ROR = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Right-moving modes expose the LSB on the serial output, left-moving the MSB.
   function automatic logic mode_is_right(input mode_e m);
      return (m == MODE_SHR) || (m == MODE_ROR);
   endfunction

endpackage

// File: rtl/shift_engine_shift_step.sv
// One combinational shift/rotate step of a WIDTH-bit word; reused by multi-lane variants.
module shift_step
   import shift_engine_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] r,
   input  mode_e            mode,
   input  logic             sin,
   output logic [WIDTH-1:0] r_next_c
);

   always_comb begin
      r_next_c = r;
      unique case (mode)
         MODE_SHL: r_next_c = {r[WIDTH-2:0], sin};
         MODE_SHR: r_next_c = {sin, r[WIDTH-1:1]};
         MODE_ROL: r_next_c = {r[WIDTH-2:0], r[WIDTH-1]};
         MODE_ROR: r_next_c = {r[0], r[WIDTH-1:1]};
         default:  r_next_c = r;
      endcase
   end

endmodule

// File: rtl/shift_engine.sv
// Programmable shift/rotate register with parallel load, serial I/O and start/busy/done handshake.
module shift_engine
   import shift_engine_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [1:0]       mode,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic             sin,
   input  logic             load,
   input  logic [WIDTH-1:0] pdata_in,
   output logic [WIDTH-1:0] pdata_out,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   mode_e            mode_q, mode_d;
   mode_e            eff_mode_c;
   logic [WIDTH-1:0] step_c;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .r        (data_q),
      .mode     (mode_q),
      .sin      (sin),
      .r_next_c (step_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         rem_q   <= '0;
         mode_q  <= MODE_SHL;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
      end
   end

   // Next-state and datapath update; load wins over start in IDLE.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      mode_d  = mode_q;
      unique case (state_q)
         ST_IDLE: begin
            if (load) begin
               data_d = pdata_in;
            end else if (start) begin
               if (count != '0) begin
                  mode_d  = mode_e'(mode);
                  rem_d   = count;
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (ena) begin
               data_d = step_c;
               rem_d  = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Serial output follows the live mode only while idle, otherwise the latched run mode.
   assign eff_mode_c = (state_q == ST_IDLE) ? mode_e'(mode) : mode_q;
   assign sout       = mode_is_right(eff_mode_c) ? data_q[0] : data_q[WIDTH-1];
   assign pdata_out  = data_q;
   assign busy       = (state_q == ST_RUN);
   assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_engine.sv
// Directed scoreboard bench for shift_engine at WIDTH=8.
module tb_shift_engine;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = 4;

   typedef struct packed {
      logic [W-1:0] data;
      logic         so;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ena;
   logic [1:0]    mode;
   logic          start;
   logic [CW-1:0] count;
   logic          sin;
   logic          load;
   logic [W-1:0]  pdata_in;
   logic [W-1:0]  pdata_out;
   logic          sout;
   logic          busy;
   logic          done;

   int            errors = 0;
   int            checks = 0;
   exp_t          sb[$];
   logic [W-1:0]  model_q;

   shift_engine #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .mode      (mode),
      .start     (start),
      .count     (count),
      .sin       (sin),
      .load      (load),
      .pdata_in  (pdata_in),
      .pdata_out (pdata_out),
      .sout      (sout),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] model_step(input logic [W-1:0] r, input logic [1:0] m,
                                                input logic s);
      case (m)
         2'd0:    return (r << 1) | W'(s);
         2'd1:    return (r >> 1) | (W'(s) << (W - 1));
         2'd2:    return (r << 1) | (r >> (W - 1));
         default: return (r >> 1) | (r << (W - 1));
      endcase
   endfunction

   task automatic do_load(input logic [W-1:0] v);
      load = 1'b1;
      pdata_in = v;
      tick();
      load = 1'b0;
      model_q = v;
      check("load_data", 32'(pdata_out), 32'(v));
   endtask

   // Run n steps; optional stall after step stall_after, optional start/load noise while busy.
   task automatic run(input logic [1:0] m, input int n, input logic s, input int stall_after,
                      input int stall_cyc, input bit noise);
      logic [W-1:0] r;
      exp_t         e;
      r = model_q;
      for (int i = 0; i < n; i++) begin
         r = model_step(r, m, s);
         e.data = r;
         e.so   = (m == 2'd1 || m == 2'd3) ? r[0] : r[W-1];
         sb.push_back(e);
      end
      start = 1'b1; mode = m; count = CW'(n); sin = s; ena = 1'b1;
      tick();
      start = 1'b0;
      mode = ~m;
      check("start_busy", 32'(busy), 32'(1));
      check("start_noshift", 32'(pdata_out), 32'(model_q));
      if (noise) begin
         start = 1'b1; load = 1'b1; pdata_in = 8'hA5; count = CW'(1);
      end
      for (int i = 1; i <= n; i++) begin
         tick();
         e = sb.pop_front();
         check("step_data", 32'(pdata_out), 32'(e.data));
         check("step_sout", 32'(sout), 32'(e.so));
         check("step_busy", 32'(busy), 32'(i < n));
         check("step_done", 32'(done), 32'(i == n));
         if (i == stall_after) begin
            ena = 1'b0;
            repeat (stall_cyc) begin
               tick();
               check("stall_data", 32'(pdata_out), 32'(e.data));
               check("stall_busy", 32'(busy), 32'(1));
               check("stall_done", 32'(done), 32'(0));
            end
            ena = 1'b1;
         end
      end
      ena = 1'b0;
      tick();
      ena = 1'b1; start = 1'b0; load = 1'b0;
      check("post_done", 32'(done), 32'(0));
      check("post_busy", 32'(busy), 32'(0));
      model_q = e.data;
      check("final_data", 32'(pdata_out), 32'(model_q));
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; mode = 2'd0; start = 1'b0; count = '0;
      sin = 1'b0; load = 1'b0; pdata_in = '0; model_q = '0;
      #12;
      check("rst_data", 32'(pdata_out), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      tick();
      rst_n = 1'b1;

      // SHL with sin=1 from 0x81
      do_load(8'h81);
      run(2'd0, 3, 1'b1, 0, 0, 1'b0);
      check("t1_final", 32'(pdata_out), 32'h0F);

      // ROR full revolution
      do_load(8'h01);
      mode = 2'd3;
      #1 check("idle_sout_live", 32'(sout), 32'(1));
      run(2'd3, 8, 1'b0, 0, 0, 1'b0);
      check("t2_final", 32'(pdata_out), 32'h01);

      // SHR with sin=1, and SHL with a two-cycle stall
      do_load(8'hC3);
      run(2'd1, 2, 1'b1, 0, 0, 1'b0);
      do_load(8'h96);
      run(2'd0, 3, 1'b0, 1, 2, 1'b0);

      // ROL past WIDTH wraps modulo WIDTH
      do_load(8'hB4);
      run(2'd2, 10, 1'b0, 0, 0, 1'b0);
      check("rol10_final", 32'(pdata_out), 32'hD2);

      // count == 0 goes straight to DONE
      start = 1'b1; count = '0;
      tick();
      start = 1'b0;
      check("c0_done", 32'(done), 32'(1));
      check("c0_busy", 32'(busy), 32'(0));
      check("c0_data", 32'(pdata_out), 32'(model_q));
      tick();
      check("c0_done_clr", 32'(done), 32'(0));

      // start/load during RUN ignored
      do_load(8'h3E);
      run(2'd3, 4, 1'b0, 0, 0, 1'b1);

      // load + start together: load only
      load = 1'b1; start = 1'b1; count = CW'(3); pdata_in = 8'h3C;
      tick();
      load = 1'b0; start = 1'b0;
      model_q = 8'h3C;
      check("ls_data", 32'(pdata_out), 32'h3C);
      check("ls_busy", 32'(busy), 32'(0));
      check("ls_done", 32'(done), 32'(0));
      tick();
      check("ls_busy2", 32'(busy), 32'(0));
      check("ls_done2", 32'(done), 32'(0));

      // async reset mid-run
      do_load(8'h5A);
      start = 1'b1; mode = 2'd2; count = CW'(5);
      tick();
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("arst_data", 32'(pdata_out), 32'(0));
      check("arst_busy", 32'(busy), 32'(0));
      check("arst_done", 32'(done), 32'(0));
      tick();
      rst_n = 1'b1;
      model_q = '0;
      run(2'd0, 2, 1'b1, 0, 0, 1'b0);
      check("arst_final", 32'(pdata_out), 32'h03);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
